// File: rtl/serial_fifo_pkg.sv
// Shared constants and types for the serial FIFO write side.
package serial_fifo_pkg;

  localparam int WORD_W = 5;
  localparam int PAT_LEN = 6;
  localparam logic [PAT_LEN-1:0] PATTERN_DEFAULT = 6'b110111;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/serial_word_packer_pattern_gate.sv
// Rotating acceptance-slot generator: walks the enable pattern LSB first,
// one slot per clock, and restarts at slot 0 on flush.
module serial_word_packer_pattern_gate
  import serial_fifo_pkg::*;
#(
  parameter int                  PAT_LEN = serial_fifo_pkg::PAT_LEN,
  parameter logic [PAT_LEN-1:0]  PATTERN = PATTERN_DEFAULT
) (
  input  logic write_clk,
  input  logic write_rst_n,
  input  logic flush,
  output logic slot_en
);

  localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  logic [IDX_W-1:0] pat_idx_reg;
  logic [IDX_W-1:0] pat_idx_next;

  // Advance every cycle regardless of traffic; wrap at the pattern end.
  always_comb begin
    pat_idx_next = pat_idx_reg + 1'b1;
    if (flush || (pat_idx_reg == IDX_W'(PAT_LEN - 1))) begin
      pat_idx_next = '0;
    end
  end

  // Slot index register.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      pat_idx_reg <= '0;
    end else begin
      pat_idx_reg <= pat_idx_next;
    end
  end

  assign slot_en = PATTERN[pat_idx_reg];

endmodule

// File: rtl/serial_word_packer.sv
// Packs a gated serial bit stream into words (first bit -> bit 0) and hands
// each word to the FIFO write port through a one-word hold register.
module serial_word_packer
  import serial_fifo_pkg::*;
#(
  parameter int                  WIDTH   = WORD_W,
  parameter int                  PAT_LEN = serial_fifo_pkg::PAT_LEN,
  parameter logic [PAT_LEN-1:0]  PATTERN = PATTERN_DEFAULT
) (
  input  logic             write_clk,
  input  logic             write_rst_n,
  input  logic             ser_valid,
  input  logic             ser_bit,
  output logic             ser_ready,
  input  logic             flush,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_wr_data,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [7:0]       words_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             slot_en;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic             hold_valid_reg;
  logic [WIDTH-1:0] hold_data_reg;
  logic             overflow_reg;
  logic [7:0]       words_out_reg;

  logic drain;
  logic last_bit;
  logic accept;
  logic word_done;
  logic ovf_set;

  serial_word_packer_pattern_gate #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_pattern_gate (
    .write_clk   (write_clk),
    .write_rst_n (write_rst_n),
    .flush       (flush),
    .slot_en     (slot_en)
  );

  // The last bit of a word may only be taken if the hold slot is free or
  // emptying this cycle; earlier bits are always safe to collect.
  assign drain     = hold_valid_reg & ~fifo_full;
  assign last_bit  = (bit_cnt_reg == CNT_W'(WIDTH - 1));
  assign ser_ready = write_rst_n & slot_en & ~(last_bit & hold_valid_reg & ~drain);
  assign accept    = ser_valid & ser_ready & ~flush;
  assign word_done = accept & last_bit;
  assign ovf_set   = ser_valid & slot_en & ~ser_ready;

  // Shift image with the incoming bit dropped into position bit_cnt.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      assign shift_next[gi] = (bit_cnt_reg == CNT_W'(gi)) ? ser_bit : shift_reg[gi];
    end
  endgenerate

  // Word assembly: flush discards the partial word, otherwise collect bits.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (flush) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (accept) begin
      shift_reg   <= shift_next;
      bit_cnt_reg <= word_done ? '0 : bit_cnt_reg + 1'b1;
    end
  end

  // Hold register: a completing word reloads it even while it drains.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else if (word_done) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= shift_next;
    end else if (drain) begin
      hold_valid_reg <= 1'b0;
    end
  end

  // Sticky overflow; a new event outranks a simultaneous clear.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      overflow_reg <= 1'b0;
    end else if (ovf_set) begin
      overflow_reg <= 1'b1;
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  // Written-word counter, wraps naturally at 8 bits.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      words_out_reg <= '0;
    end else if (drain) begin
      words_out_reg <= words_out_reg + 8'd1;
    end
  end

  assign fifo_wr_en   = drain;
  assign fifo_wr_data = hold_data_reg;
  assign overflow     = overflow_reg;
  assign words_out    = words_out_reg;

endmodule

// File: tb/tb_serial_word_packer.sv
// Directed bench for serial_word_packer: a per-cycle vector table followed by
// hand-written sequences for asynchronous reset and counter wrap.
module tb_serial_word_packer;

  logic       write_clk = 1'b0;
  logic       write_rst_n;
  logic       ser_valid;
  logic       ser_bit;
  logic       ser_ready;
  logic       flush;
  logic       fifo_full;
  logic       fifo_wr_en;
  logic [4:0] fifo_wr_data;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] words_out;

  int n_vec = 0;
  int n_bad = 0;

  serial_word_packer dut (
    .write_clk    (write_clk),
    .write_rst_n  (write_rst_n),
    .ser_valid    (ser_valid),
    .ser_bit      (ser_bit),
    .ser_ready    (ser_ready),
    .flush        (flush),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .words_out    (words_out)
  );

  always #5 write_clk = ~write_clk;

  typedef struct {
    logic       v, b, fl, full, clr;
    logic       r, w;
    logic [4:0] d;
    logic       o;
    logic [7:0] n;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, b, fl, full, clr, r, w,
                     input logic [4:0] d, input logic o, input logic [7:0] n);
    vec_t t;
    t.v = v; t.b = b; t.fl = fl; t.full = full; t.clr = clr;
    t.r = r; t.w = w; t.d = d; t.o = o; t.n = n;
    vecs.push_back(t);
  endtask

  // Compare {ser_ready, fifo_wr_en, fifo_wr_data, overflow, words_out}.
  task automatic chk(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {ser_ready, fifo_wr_en, fifo_wr_data, overflow, words_out};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b wr=%b data=%b ovf=%b words=%0d, want rdy=%b wr=%b data=%b ovf=%b words=%0d",
               name, act[15], act[14], act[13:9], act[8], act[7:0],
               exp[15], exp[14], exp[13:9], exp[8], exp[7:0]);
    end else begin
      $display("ok   %s: rdy=%b wr=%b data=%b ovf=%b words=%0d",
               name, act[15], act[14], act[13:9], act[8], act[7:0]);
    end
  endtask

  task automatic chk1(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  initial begin
    int wr_cnt;
    int cyc;

    write_rst_n = 1'b0;
    ser_valid = 0; ser_bit = 0; flush = 0; fifo_full = 0; ovf_clr = 0;

    // Slot pattern 110111: slots 0,1,2,4,5 enabled, slot 3 disabled.
    //   v  b  fl fu cl | r  w  data      o  words
    // continuous ones -> 11111
    add(1, 1, 0, 0, 0,  1, 0, 5'b00000, 0, 0);   // c0  slot0
    add(1, 1, 0, 0, 0,  1, 0, 5'b00000, 0, 0);   // c1  slot1
    add(1, 1, 0, 0, 0,  1, 0, 5'b00000, 0, 0);   // c2  slot2
    add(1, 1, 0, 0, 0,  0, 0, 5'b00000, 0, 0);   // c3  slot3 disabled, no ovf
    add(1, 1, 0, 0, 0,  1, 0, 5'b00000, 0, 0);   // c4  slot4
    add(1, 1, 0, 0, 0,  1, 0, 5'b00000, 0, 0);   // c5  slot5 last bit
    add(1, 1, 0, 0, 0,  1, 1, 5'b11111, 0, 0);   // c6  first write; bit0 of 01101
    add(1, 0, 0, 0, 0,  1, 0, 5'b11111, 0, 1);   // c7  words=1
    add(1, 1, 0, 0, 0,  1, 0, 5'b11111, 0, 1);   // c8
    add(1, 0, 0, 0, 0,  0, 0, 5'b11111, 0, 1);   // c9  disabled, bit ignored
    add(1, 1, 0, 0, 0,  1, 0, 5'b11111, 0, 1);   // c10
    add(1, 0, 0, 0, 0,  1, 0, 5'b11111, 0, 1);   // c11 completes 01101
    add(0, 0, 0, 0, 0,  1, 1, 5'b01101, 0, 1);   // c12 single-cycle write
    add(0, 0, 0, 0, 0,  1, 0, 5'b01101, 0, 2);   // c13
    // FIFO full: word A=10011 held, word B=00110 stalls at 4 bits
    add(1, 1, 0, 1, 0,  1, 0, 5'b01101, 0, 2);   // c14 slot2 A0
    add(1, 0, 0, 1, 0,  0, 0, 5'b01101, 0, 2);   // c15 slot3
    add(1, 1, 0, 1, 0,  1, 0, 5'b01101, 0, 2);   // c16 A1
    add(1, 0, 0, 1, 0,  1, 0, 5'b01101, 0, 2);   // c17 A2
    add(1, 0, 0, 1, 0,  1, 0, 5'b01101, 0, 2);   // c18 A3
    add(1, 1, 0, 1, 0,  1, 0, 5'b01101, 0, 2);   // c19 A4
    add(1, 0, 0, 1, 0,  1, 0, 5'b10011, 0, 2);   // c20 held, no write; B0
    add(1, 1, 0, 1, 0,  0, 0, 5'b10011, 0, 2);   // c21 slot3
    add(1, 1, 0, 1, 0,  1, 0, 5'b10011, 0, 2);   // c22 B1
    add(1, 1, 0, 1, 0,  1, 0, 5'b10011, 0, 2);   // c23 B2
    add(1, 0, 0, 1, 0,  1, 0, 5'b10011, 0, 2);   // c24 B3
    add(1, 0, 0, 1, 0,  0, 0, 5'b10011, 0, 2);   // c25 stalled -> overflow
    add(0, 0, 0, 1, 0,  0, 0, 5'b10011, 1, 2);   // c26 overflow sticky
    add(0, 0, 0, 1, 0,  0, 0, 5'b10011, 1, 2);   // c27
    add(1, 0, 0, 0, 0,  1, 1, 5'b10011, 1, 2);   // c28 release: drain + reload
    add(0, 0, 0, 0, 1,  1, 1, 5'b00110, 1, 3);   // c29 second write, ovf_clr
    add(1, 1, 0, 0, 0,  1, 0, 5'b00110, 0, 4);   // c30 slot0 partial bit
    add(1, 1, 0, 0, 0,  1, 0, 5'b00110, 0, 4);   // c31
    add(1, 1, 0, 0, 0,  1, 0, 5'b00110, 0, 4);   // c32 3 partial bits
    add(0, 0, 1, 0, 0,  0, 0, 5'b00110, 0, 4);   // c33 flush at slot3
    add(1, 0, 0, 0, 0,  1, 0, 5'b00110, 0, 4);   // c34 slot0 again, Q0
    add(1, 0, 0, 0, 0,  1, 0, 5'b00110, 0, 4);   // c35 Q1
    add(1, 1, 0, 0, 0,  1, 0, 5'b00110, 0, 4);   // c36 Q2
    add(1, 1, 0, 0, 0,  0, 0, 5'b00110, 0, 4);   // c37 slot3 ignored
    add(1, 0, 0, 0, 0,  1, 0, 5'b00110, 0, 4);   // c38 Q3
    add(1, 0, 0, 0, 0,  1, 0, 5'b00110, 0, 4);   // c39 Q4
    add(0, 0, 1, 0, 0,  1, 1, 5'b00100, 0, 4);   // c40 flush while draining
    add(0, 0, 0, 0, 0,  1, 0, 5'b00100, 0, 5);   // c41 slot0 (restarted)
    add(0, 0, 0, 0, 0,  1, 0, 5'b00100, 0, 5);   // c42 slot1
    add(0, 0, 0, 0, 0,  1, 0, 5'b00100, 0, 5);   // c43 slot2
    add(0, 0, 0, 0, 0,  0, 0, 5'b00100, 0, 5);   // c44 slot3

    repeat (2) @(negedge write_clk);
    #1;
    chk("reset_state", 16'h0000);

    @(negedge write_clk);
    write_rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      ser_valid = vecs[i].v; ser_bit = vecs[i].b; flush = vecs[i].fl;
      fifo_full = vecs[i].full; ovf_clr = vecs[i].clr;
      #1;
      chk($sformatf("vec%0d", i),
          {vecs[i].r, vecs[i].w, vecs[i].d, vecs[i].o, vecs[i].n});
      @(negedge write_clk);
    end

    // Fill hold + 4 bits under full, then hit an enabled slot -> overflow.
    ser_valid = 1; ser_bit = 1; flush = 0; ovf_clr = 0; fifo_full = 1;
    repeat (12) @(negedge write_clk);
    ser_valid = 0;
    #1;
    chk("pre_reset", {1'b0, 1'b0, 5'b11111, 1'b1, 8'd5});
    #2;
    write_rst_n = 1'b0;   // mid-cycle, no clock edge involved
    #1;
    chk("async_reset", 16'h0000);
    @(negedge write_clk);
    write_rst_n = 1'b1;
    fifo_full = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk1($sformatf("post_reset_wr%0d", i), {7'd0, fifo_wr_en}, 8'd0);
      @(negedge write_clk);
    end
    chk1("post_reset_words", words_out, 8'd0);

    // Stream 256 all-ones words; counter must wrap back to zero.
    ser_valid = 1; ser_bit = 1;
    wr_cnt = 0;
    cyc = 0;
    while (wr_cnt < 256 && cyc < 2000) begin
      #1;
      if (fifo_wr_en) begin
        wr_cnt++;
        if (wr_cnt == 1 || wr_cnt == 256) begin
          chk1($sformatf("wrap_data%0d", wr_cnt), {3'd0, fifo_wr_data}, 8'h1f);
        end
        if (wr_cnt == 256) chk1("words_before_wrap", words_out, 8'd255);
      end
      @(negedge write_clk);
      cyc++;
    end
    if (wr_cnt < 256) begin
      n_vec++;
      n_bad++;
      $display("FAIL wrap_timeout: got %0d writes want 256", wr_cnt);
    end
    ser_valid = 0;
    #1;
    chk1("words_wrapped", words_out, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_word_packer.md
Name: serial_word_packer

Overview:
- Upstream write-side stage of the serial FIFO. Collects a serial bit stream into WIDTH-bit words, LSB first.
- Presents each completed word to the FIFO write port, holding it while the FIFO reports full.
- Acceptance is gated by a rotating enable pattern, the write-clock-modulation scheme, so only pattern-enabled cycles consume bits.
- Single clock domain: write_clk.

Parameters:
- WIDTH, 5: bits per packed word (matches FIFO data width).
- PAT_LEN, 6: length of the acceptance enable pattern.
- PATTERN, 6'b110111: enable pattern; bit i enables acceptance on pattern slot i, consumed LSB first.

Ports:
- write_clk  in  1  write-domain clock, rising edge.
- write_rst_n  in  1  asynchronous active-low reset.
- ser_valid  in  1  serial bit present.
- ser_bit  in  1  serial data bit.
- ser_ready  out  1  bit accepted this cycle when ser_valid & ser_ready.
- flush  in  1  synchronous: discard partial word, restart pattern.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  write strobe to FIFO, one cycle per word.
- fifo_wr_data  out  WIDTH  word to FIFO; bit 0 = first received bit.
- overflow  out  1  sticky: ser_valid seen while ser_ready low on an enabled slot.
- ovf_clr  in  1  synchronous clear of overflow.
- words_out  out  8  count of words written to FIFO, wraps 255->0.

Behaviour:
- Reset (async, write_rst_n=0) sets:
  - shift register = 0, bit_cnt = 0, pat_idx = 0
  - hold_valid = 0, hold_data = 0
  - fifo_wr_en = 0, fifo_wr_data = 0, overflow = 0, words_out = 0
  - ser_ready = 0 while reset is asserted.
- Pattern: slot_en = PATTERN[pat_idx]. pat_idx increments every cycle, wrapping PAT_LEN-1 -> 0, regardless of ser_valid.
- ser_ready = slot_en & ~(bit_cnt==WIDTH-1 & hold_valid & ~drain), where drain = hold_valid & ~fifo_full.
- Accept: ser_bit is written into shift position bit_cnt, then bit_cnt increments.
  - When the accepted bit is bit WIDTH-1: the full word moves to hold_data, hold_valid is set, and bit_cnt returns to 0.
- Drain (combinational output):
  - fifo_wr_en = drain, fifo_wr_data = hold_data.
  - On a drain cycle hold_valid clears, unless a new word completes in the same cycle, in which case hold reloads and stays valid.
  - Throughput: one word per WIDTH enabled slots, no bubble.
- Latency: first fifo_wr_en is asserted in the cycle after the edge that accepted the last bit, provided fifo_full=0.
- fifo_full=1:
  - hold_data is held stable and fifo_wr_en stays 0.
  - Assembly continues up to WIDTH-1 bits, then ser_ready drops.
- overflow sets on any cycle with ser_valid & slot_en & ~ser_ready. It clears only via ovf_clr; if set and clear coincide, set wins.
  - Bits on disabled slots (slot_en=0) are ignored and do not raise overflow.
- flush:
  - Clears bit_cnt, the shift register and pat_idx next edge; no bit is accepted in the flush cycle.
  - hold_valid/hold_data are unaffected, so a completed word still drains.
  - Flush with hold_valid & drain: the write occurs normally.
- words_out increments on each fifo_wr_en and wraps modulo 256.
- Reset mid-word: partial word is lost, no FIFO write.

Decomposition:
- Package serial_fifo_pkg: WORD_W=5, PAT_LEN=6, PATTERN_DEFAULT=6'b110111, typedef logic [WORD_W-1:0] word_t.
- One natural sub-module: pattern_gate (pat_idx counter plus PATTERN bit select, with flush restart), producing slot_en.
- Packer and hold register stay in the top module.

Test Plan:
- Reset release, ser_valid=1, ser_bit=1 continuous, fifo_full=0, PATTERN=110111:
  - bits accepted on slots 0,1,2,4,5,0,...
  - first fifo_wr_en with data 5'b11111 one cycle after the 5th accepted bit; words_out=1.
- Serial sequence 1,0,1,1,0 on enabled slots -> fifo_wr_data=5'b01101, single-cycle fifo_wr_en.
- fifo_full=1 held while 2 words stream in:
  - first word is held in hold_data, fifo_wr_en=0
  - ser_ready drops after 4 bits of the second word
  - overflow=1 on the next enabled ser_valid.
  - Release fifo_full -> two consecutive writes with the correct data.
- Back-to-back: word completes in the same cycle hold drains -> hold reloads, no lost word, words_out counts both.
- flush after 3 accepted bits -> next 5 accepted bits form the word; the old partial bits never appear; pat_idx restarts at 0.
- Assert write_rst_n=0 mid-word and asynchronously mid-cycle -> all outputs 0 immediately, no write after release; ovf_clr clears overflow.
